// File: rtl/jtag_pkg.sv
// Shared types and default constants for the JTAG TAP controller.
// State codes follow the classic 1149.1 reference encoding.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_EX2DR   = 4'h0,
    TAP_EX1DR   = 4'h1,
    TAP_SHDR    = 4'h2,
    TAP_PAUSEDR = 4'h3,
    TAP_SELIR   = 4'h4,
    TAP_UPDDR   = 4'h5,
    TAP_CAPDR   = 4'h6,
    TAP_SELDR   = 4'h7,
    TAP_EX2IR   = 4'h8,
    TAP_EX1IR   = 4'h9,
    TAP_SHIR    = 4'hA,
    TAP_PAUSEIR = 4'hB,
    TAP_RTI     = 4'hC,
    TAP_UPDIR   = 4'hD,
    TAP_CAPIR   = 4'hE,
    TAP_TLR     = 4'hF
  } tap_state_e;

  // Which data register sits between tdi and tdo during a DR scan.
  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_CHAIN
  } dr_sel_e;

  localparam int unsigned IR_WIDTH_DEF     = 5;
  localparam logic [4:0]  IDCODE_INSTR_DEF = 5'h01;
  localparam logic [4:0]  BYPASS_INSTR_DEF = 5'h1F;
  localparam logic [4:0]  CHAIN_BASE_DEF   = 5'h10;
  localparam logic [31:0] IDCODE_VALUE_DEF = 32'h0000_0001;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state machine with one-hot decodes of the states that
// the register datapaths act on.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       tms_i,
  output tap_state_e state_o,
  output logic       tlr_o,
  output logic       capture_ir_o,
  output logic       shift_ir_o,
  output logic       update_ir_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o
);

  tap_state_e state_q, state_d;

  // NOTE: state registers use non-blocking (<=) only; blocking (=) is reserved for always_comb.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= TAP_TLR;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TAP_TLR:     state_d = tms_i ? TAP_TLR     : TAP_RTI;
      TAP_RTI:     state_d = tms_i ? TAP_SELDR   : TAP_RTI;
      TAP_SELDR:   state_d = tms_i ? TAP_SELIR   : TAP_CAPDR;
      TAP_CAPDR:   state_d = tms_i ? TAP_EX1DR   : TAP_SHDR;
      TAP_SHDR:    state_d = tms_i ? TAP_EX1DR   : TAP_SHDR;
      TAP_EX1DR:   state_d = tms_i ? TAP_UPDDR   : TAP_PAUSEDR;
      TAP_PAUSEDR: state_d = tms_i ? TAP_EX2DR   : TAP_PAUSEDR;
      TAP_EX2DR:   state_d = tms_i ? TAP_UPDDR   : TAP_SHDR;
      TAP_UPDDR:   state_d = tms_i ? TAP_SELDR   : TAP_RTI;
      TAP_SELIR:   state_d = tms_i ? TAP_TLR     : TAP_CAPIR;
      TAP_CAPIR:   state_d = tms_i ? TAP_EX1IR   : TAP_SHIR;
      TAP_SHIR:    state_d = tms_i ? TAP_EX1IR   : TAP_SHIR;
      TAP_EX1IR:   state_d = tms_i ? TAP_UPDIR   : TAP_PAUSEIR;
      TAP_PAUSEIR: state_d = tms_i ? TAP_EX2IR   : TAP_PAUSEIR;
      TAP_EX2IR:   state_d = tms_i ? TAP_UPDIR   : TAP_SHIR;
      TAP_UPDIR:   state_d = tms_i ? TAP_SELDR   : TAP_RTI;
      default:     state_d = TAP_TLR;
    endcase
  end

  assign state_o      = state_q;
  assign tlr_o        = (state_q == TAP_TLR);
  assign capture_ir_o = (state_q == TAP_CAPIR);
  assign shift_ir_o   = (state_q == TAP_SHIR);
  assign update_ir_o  = (state_q == TAP_UPDIR);
  assign capture_dr_o = (state_q == TAP_CAPDR);
  assign shift_dr_o   = (state_q == TAP_SHDR);
  assign update_dr_o  = (state_q == TAP_UPDDR);

endmodule

// File: rtl/jtag_tap_controller.sv
// TAP controller: IR, IDCODE and BYPASS registers plus one-hot steering of
// the external capture/update scan chains.
module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter int unsigned          IR_WIDTH     = IR_WIDTH_DEF,
  parameter int unsigned          NUM_CHAINS   = 4,
  parameter logic [IR_WIDTH-1:0]  CHAIN_BASE   = IR_WIDTH'(CHAIN_BASE_DEF),
  parameter logic [IR_WIDTH-1:0]  IDCODE_INSTR = IR_WIDTH'(IDCODE_INSTR_DEF),
  parameter logic [31:0]          IDCODE_VALUE = IDCODE_VALUE_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tms,
  input  logic                  tdi,
  output logic                  tdo,
  output logic                  tdo_en,
  output logic                  chain_shift,
  output logic                  chain_capture,
  output logic                  chain_update,
  output logic                  chain_data,
  output logic [NUM_CHAINS-1:0] chain_sel,
  input  logic [NUM_CHAINS-1:0] chain_tdo,
  output logic [IR_WIDTH-1:0]   instruction,
  output logic [3:0]            tap_state
);

  tap_state_e state;
  logic tlr, capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr;

  jtag_tap_fsm u_fsm (
    .clock        (clock),
    .reset        (reset),
    .tms_i        (tms),
    .state_o      (state),
    .tlr_o        (tlr),
    .capture_ir_o (capture_ir),
    .shift_ir_o   (shift_ir),
    .update_ir_o  (update_ir),
    .capture_dr_o (capture_dr),
    .shift_dr_o   (shift_dr),
    .update_dr_o  (update_dr)
  );

  logic [IR_WIDTH-1:0] instruction_q, instruction_d;
  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic [31:0]         idcode_sr_q, idcode_sr_d;
  logic                bypass_q, bypass_d;

  logic [IR_WIDTH-1:0] chain_off;
  logic                idcode_hit, chain_hit;
  dr_sel_e             dr_sel;

  // Decode depends only on the updated instruction, so chain_sel cannot move mid-DR-scan.
  always_comb begin
    chain_off  = instruction_q - CHAIN_BASE;
    idcode_hit = (instruction_q == IDCODE_INSTR);
    chain_hit  = !idcode_hit && (instruction_q >= CHAIN_BASE) && (32'(chain_off) < NUM_CHAINS);
    dr_sel     = DR_BYPASS;
    if (idcode_hit)     dr_sel = DR_IDCODE;
    else if (chain_hit) dr_sel = DR_CHAIN;
    chain_sel = '0;
    for (int unsigned k = 0; k < NUM_CHAINS; k++) begin
      chain_sel[k] = chain_hit && (32'(chain_off) == k);
    end
  end

  always_comb begin
    ir_sr_d       = ir_sr_q;
    instruction_d = instruction_q;
    idcode_sr_d   = idcode_sr_q;
    bypass_d      = bypass_q;

    if (capture_ir)    ir_sr_d = IR_WIDTH'(2'b01);
    else if (shift_ir) ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};

    if (tlr)            instruction_d = IDCODE_INSTR;
    else if (update_ir) instruction_d = ir_sr_q;

    if (dr_sel == DR_IDCODE) begin
      if (capture_dr)    idcode_sr_d = IDCODE_VALUE;
      else if (shift_dr) idcode_sr_d = {tdi, idcode_sr_q[31:1]};
    end
    if (dr_sel == DR_BYPASS) begin
      if (capture_dr)    bypass_d = 1'b0;
      else if (shift_dr) bypass_d = tdi;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instruction_q <= IDCODE_INSTR;
      ir_sr_q       <= '0;
      idcode_sr_q   <= IDCODE_VALUE;
      bypass_q      <= 1'b0;
    end else begin
      instruction_q <= instruction_d;
      ir_sr_q       <= ir_sr_d;
      idcode_sr_q   <= idcode_sr_d;
      bypass_q      <= bypass_d;
    end
  end

  // tdo shows the bit leaving on the coming edge, i.e. bit 0 of the active register.
  always_comb begin
    tdo = 1'b0;
    if (shift_ir) begin
      tdo = ir_sr_q[0];
    end else if (shift_dr) begin
      case (dr_sel)
        DR_IDCODE: tdo = idcode_sr_q[0];
        DR_CHAIN:  tdo = |(chain_sel & chain_tdo);
        default:   tdo = bypass_q;
      endcase
    end
  end

  assign tdo_en        = shift_ir | shift_dr;
  assign chain_capture = capture_dr & chain_hit;
  assign chain_shift   = shift_dr & chain_hit;
  assign chain_update  = update_dr & chain_hit;
  assign chain_data    = tdi;
  assign instruction   = instruction_q;
  assign tap_state     = state;

endmodule
